// File: rtl/cart_bus_arbiter.sv
// Two-port arbiter/sequencer for the cartridge bus: grants one transaction at a time,
// strobes cart_iface, watches its busy flag with a timeout and acks the winning port.
module cart_bus_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter bit RR_EN     = 1'b1
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic [1:0]  port_en,
  input  logic        p0_rd,
  input  logic        p0_wr,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic [7:0]  p0_rdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_rd,
  input  logic        p1_wr,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic [7:0]  p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        c_rd,
  output logic        c_wr,
  output logic [15:0] c_addr,
  output logic [7:0]  c_din,
  input  logic [7:0]  c_dout,
  input  logic        c_busy,
  output logic [1:0]  grant,
  output logic        bus_active
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BSY,
    WAIT_DONE,
    ACK
  } state_t;

  // Last timer value before a wait state gives up: 2^TIMEOUT_W-1 cycles spent waiting.
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic [TIMEOUT_W-1:0] timer;
  logic                 is_wr;
  logic                 err_flag;
  logic                 last_owner;
  logic                 req0;
  logic                 req1;
  logic                 pick1;
  logic                 timed_out;

  always_comb begin
    req0       = (p0_rd | p0_wr) & port_en[0];
    req1       = (p1_rd | p1_wr) & port_en[1];
    pick1      = req1 && (!req0 || (RR_EN && !last_owner));
    timed_out  = (timer == TIMER_LAST);
    state_next = state;
    case (state)
      IDLE:      if (req0 || req1) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BSY;
      WAIT_BSY:  if (c_busy) state_next = WAIT_DONE;
                 else if (timed_out) state_next = ACK;
      WAIT_DONE: if (!c_busy || timed_out) state_next = ACK;
      ACK:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_8m) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Timer is cleared on entry to each wait state and saturates rather than wrapping.
  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      timer      <= '0;
      is_wr      <= 1'b0;
      err_flag   <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      c_addr     <= '0;
      c_din      <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant    <= pick1 ? 2'b10 : 2'b01;
            c_addr   <= pick1 ? p1_addr : p0_addr;
            c_din    <= pick1 ? p1_wdata : p0_wdata;
            is_wr    <= pick1 ? p1_wr : p0_wr;
            err_flag <= 1'b0;
          end
        end
        ISSUE: timer <= '0;
        WAIT_BSY: begin
          if (c_busy)             timer    <= '0;
          else if (timed_out)     err_flag <= 1'b1;
          else if (timer != '1)   timer    <= timer + TIMER_ONE;
        end
        WAIT_DONE: begin
          if (!c_busy) begin
            if (!is_wr && grant[0]) p0_rdata <= c_dout;
            if (!is_wr && grant[1]) p1_rdata <= c_dout;
          end else if (timed_out) begin
            err_flag <= 1'b1;
          end else if (timer != '1) begin
            timer <= timer + TIMER_ONE;
          end
        end
        ACK: begin
          last_owner <= grant[1];
          grant      <= 2'b00;
        end
        default: grant <= 2'b00;
      endcase
    end
  end

  always_comb begin
    c_rd       = (state == ISSUE) && !is_wr;
    c_wr       = (state == ISSUE) && is_wr;
    p0_ack     = (state == ACK) && grant[0];
    p1_ack     = (state == ACK) && grant[1];
    p0_err     = p0_ack && err_flag;
    p1_err     = p1_ack && err_flag;
    bus_active = (state != IDLE);
  end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: a round-robin DUT and a fixed-priority DUT share
// inputs, with a small c_busy model driven from the round-robin DUT's strobes.
module tb_cart_bus_arbiter;

  logic        clk_8m = 1'b0;
  logic        rst_n;
  logic [1:0]  port_en;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        c_rd, c_wr, c_busy, bus_active;
  logic [15:0] c_addr;
  logic [7:0]  c_din, c_dout;
  logic [1:0]  grant;

  logic [7:0]  f_p0_rdata, f_p1_rdata, f_c_din;
  logic        f_p0_ack, f_p0_err, f_p1_ack, f_p1_err, f_c_rd, f_c_wr, f_bus_active;
  logic [15:0] f_c_addr;
  logic [1:0]  f_grant;

  int tests_run = 0;
  int tests_failed = 0;

  always #62 clk_8m = ~clk_8m;

  cart_bus_arbiter #(.TIMEOUT_W(4), .RR_EN(1'b1)) dut (
    .clk_8m(clk_8m), .rst_n(rst_n), .port_en(port_en),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_din(c_din),
    .c_dout(c_dout), .c_busy(c_busy), .grant(grant), .bus_active(bus_active)
  );

  cart_bus_arbiter #(.TIMEOUT_W(4), .RR_EN(1'b0)) dut_fixed (
    .clk_8m(clk_8m), .rst_n(rst_n), .port_en(port_en),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(f_p0_rdata), .p0_ack(f_p0_ack), .p0_err(f_p0_err),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(f_p1_rdata), .p1_ack(f_p1_ack), .p1_err(f_p1_err),
    .c_rd(f_c_rd), .c_wr(f_c_wr), .c_addr(f_c_addr), .c_din(f_c_din),
    .c_dout(c_dout), .c_busy(c_busy), .grant(f_grant), .bus_active(f_bus_active)
  );

  // busy_mode: 0 = busy for busy_len cycles after each strobe, 1 = never busy, 2 = stuck busy
  int busy_len = 3;
  int busy_mode = 0;
  int busy_cnt = 0;
  always @(posedge clk_8m) begin
    if (c_rd || c_wr) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign c_busy = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? 1'b0 : (busy_cnt != 0);

  int rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic [15:0] strobe_addr;
  logic [7:0]  strobe_din;
  logic [1:0]  glog_a [0:31];
  logic [1:0]  glog_f [0:31];
  int ga_n = 0, gf_n = 0;
  always @(negedge clk_8m) begin
    if (c_rd) rd_cnt++;
    if (c_wr) wr_cnt++;
    if (c_rd || c_wr) begin
      strobe_addr = c_addr;
      strobe_din  = c_din;
      if (ga_n < 32) begin glog_a[ga_n] = grant; ga_n++; end
    end
    if ((f_c_rd || f_c_wr) && gf_n < 32) begin glog_f[gf_n] = f_grant; gf_n++; end
    if (p0_ack) ack0_cnt++;
    if (p1_ack) ack1_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request from a negedge, waits for its ack and reports latency in cycles,
  // counting the cycle the request was raised as cycle 1.
  task automatic applyStimulus(input int port, input logic wr, input logic [15:0] addr,
                               input logic [7:0] wdata, output int lat, output logic err_o);
    logic done;
    done = 1'b0; lat = 1; err_o = 1'b0;
    if (port == 0) begin p0_rd = !wr; p0_wr = wr; p0_addr = addr; p0_wdata = wdata; end
    else           begin p1_rd = !wr; p1_wr = wr; p1_addr = addr; p1_wdata = wdata; end
    while (!done && lat < 100) begin
      @(negedge clk_8m);
      lat++;
      if ((port == 0) ? p0_ack : p1_ack) begin
        done  = 1'b1;
        err_o = (port == 0) ? p0_err : p1_err;
      end
    end
    checkOutput("ack_arrived", {63'd0, done}, 64'd1);
    p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
    repeat (2) @(negedge clk_8m);
  endtask

  task automatic waitStrobe();
    for (int i = 0; i < 50 && !(c_rd || c_wr); i++) @(negedge clk_8m);
    checkOutput("strobe_seen", {63'd0, c_rd | c_wr}, 64'd1);
  endtask

  function automatic logic [63:0] allOutputs();
    return {15'd0, c_rd, c_wr, c_addr, c_din, p0_ack, p0_err, p0_rdata,
            p1_ack, p1_err, p1_rdata, grant, bus_active};
  endfunction

  initial begin
    int lat, rd0, wr0, a0, a1, n;
    logic err;
    int ack_ord [0:3];
    rst_n = 0; port_en = 2'b11;
    p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    c_dout = 8'hCE;
    repeat (3) @(negedge clk_8m);
    checkOutput("reset_outputs", allOutputs(), 64'd0);
    rst_n = 1;
    @(negedge clk_8m);

    // Single read from port 0, busy for 3 cycles: ack in cycle 7.
    rd0 = rd_cnt; wr0 = wr_cnt;
    applyStimulus(0, 1'b0, 16'h0104, 8'h00, lat, err);
    checkOutput("read_latency", lat, 7);
    checkOutput("read_err", {63'd0, err}, 64'd0);
    checkOutput("read_rdata", {56'd0, p0_rdata}, 64'hCE);
    checkOutput("read_rd_pulses", rd_cnt - rd0, 1);
    checkOutput("read_wr_pulses", wr_cnt - wr0, 0);
    checkOutput("read_addr", {48'd0, strobe_addr}, 64'h0104);

    // Single write from port 1.
    rd0 = rd_cnt; wr0 = wr_cnt;
    applyStimulus(1, 1'b1, 16'h2000, 8'h05, lat, err);
    checkOutput("write_latency", lat, 7);
    checkOutput("write_err", {63'd0, err}, 64'd0);
    checkOutput("write_wr_pulses", wr_cnt - wr0, 1);
    checkOutput("write_rd_pulses", rd_cnt - rd0, 0);
    checkOutput("write_din", {56'd0, strobe_din}, 64'h05);
    checkOutput("write_addr", {48'd0, strobe_addr}, 64'h2000);
    checkOutput("write_rdata_kept", {56'd0, p1_rdata}, 64'h00);

    // Contention: both ports hold reads for four transactions.
    busy_len = 1;
    ga_n = 0; gf_n = 0; n = 0;
    p0_rd = 1; p0_addr = 16'h0300; p1_rd = 1; p1_addr = 16'h0400;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk_8m);
      if (p0_ack) begin ack_ord[n] = 0; n++; end
      if (p1_ack) begin ack_ord[n] = 1; n++; end
    end
    p0_rd = 0; p1_rd = 0;
    checkOutput("contention_acks", n, 4);
    repeat (3) @(negedge clk_8m);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), {62'd0, glog_a[i]}, (i % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("rr_ack%0d", i), ack_ord[i], i % 2);
      checkOutput($sformatf("fixed_grant%0d", i), {62'd0, glog_f[i]}, 64'd1);
    end

    // Timeouts: busy never rises, then busy stuck high.
    c_dout = 8'h3C;
    busy_mode = 1;
    applyStimulus(0, 1'b0, 16'h0111, 8'h00, lat, err);
    checkOutput("to_bsy_latency", lat, 18);
    checkOutput("to_bsy_err", {63'd0, err}, 64'd1);
    checkOutput("to_bsy_rdata_kept", {56'd0, p0_rdata}, 64'hCE);
    busy_mode = 2;
    applyStimulus(0, 1'b0, 16'h0222, 8'h00, lat, err);
    checkOutput("to_done_latency", lat, 19);
    checkOutput("to_done_err", {63'd0, err}, 64'd1);
    checkOutput("to_done_rdata_kept", {56'd0, p0_rdata}, 64'hCE);
    busy_mode = 0;
    busy_len = 2;
    @(negedge clk_8m);

    // Port 0 disabled; port 1 enable dropped mid-transaction still completes.
    a0 = ack0_cnt;
    port_en = 2'b10;
    p0_rd = 1; p0_addr = 16'h0500; p1_rd = 1; p1_addr = 16'h0600;
    waitStrobe();
    checkOutput("en_grant", {62'd0, grant}, 64'd2);
    port_en = 2'b00;
    for (int i = 0; i < 50 && !(p0_ack || p1_ack); i++) @(negedge clk_8m);
    checkOutput("en_p1_ack", {63'd0, p1_ack}, 64'd1);
    p1_rd = 0;
    repeat (5) @(negedge clk_8m);
    checkOutput("en_idle", {63'd0, bus_active}, 64'd0);
    checkOutput("en_p0_no_ack", ack0_cnt - a0, 0);
    p0_rd = 0; port_en = 2'b11;
    @(negedge clk_8m);

    // Reset during WAIT_DONE abandons the transaction; a pending port 1 read follows.
    busy_len = 5;
    a0 = ack0_cnt; a1 = ack1_cnt;
    p0_rd = 1; p0_addr = 16'h0700;
    waitStrobe();
    repeat (2) @(negedge clk_8m);
    checkOutput("pre_reset_active", {63'd0, bus_active}, 64'd1);
    rst_n = 0;
    @(negedge clk_8m);
    checkOutput("midreset_outputs", allOutputs(), 64'd0);
    p0_rd = 0; p1_rd = 1; p1_addr = 16'h0800; c_dout = 8'h5A;
    repeat (6) @(negedge clk_8m);
    checkOutput("reset_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
    busy_len = 2;
    rst_n = 1;
    for (int i = 0; i < 50 && !p1_ack; i++) @(negedge clk_8m);
    checkOutput("post_reset_ack", {63'd0, p1_ack}, 64'd1);
    checkOutput("post_reset_err", {63'd0, p1_err}, 64'd0);
    checkOutput("post_reset_rdata", {56'd0, p1_rdata}, 64'h5A);
    checkOutput("post_reset_addr", {48'd0, c_addr}, 64'h0800);
    p1_rd = 0;
    repeat (3) @(negedge clk_8m);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
